// File: rtl/debug_probe_pkg.sv
// Scan-code constants and key-decode helpers shared by the debug probe monitor.
package debug_probe_pkg;

  localparam logic [8:0] KEY_NEXT = 9'h031;
  localparam logic [8:0] KEY_PREV = 9'h03A;
  localparam logic [8:0] KEY_HOLD = 9'h033;
  localparam logic [8:0] KEY_IRQ  = 9'h043;
  localparam logic [3:0] NO_CHAN  = 4'd15;

  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_CHAN = 3'd1,
    ACT_NEXT = 3'd2,
    ACT_PREV = 3'd3,
    ACT_HOLD = 3'd4,
    ACT_IRQ  = 3'd5
  } key_act_e;

  // Channel keys P,A,B,C,R,D,S,F map to channels 0..7.
  function automatic logic [3:0] ch_key_index(input logic [8:0] code);
    logic [3:0] idx;
    case (code)
      9'h04D:  idx = 4'd0;
      9'h01C:  idx = 4'd1;
      9'h032:  idx = 4'd2;
      9'h021:  idx = 4'd3;
      9'h02D:  idx = 4'd4;
      9'h023:  idx = 4'd5;
      9'h01B:  idx = 4'd6;
      9'h02B:  idx = 4'd7;
      default: idx = NO_CHAN;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/debug_probe_mux_if.sv
// Probe, keyboard, IRQ and digit-bus signals of the debug probe monitor.
interface debug_probe_mux_if #(
  parameter int CH_COUNT = 8,
  parameter int DATA_W   = 16
);
  localparam int SEL_W  = $clog2(CH_COUNT);
  localparam int DIGITS = DATA_W / 4;

  logic [CH_COUNT*DATA_W-1:0] probeBus;
  logic [8:0]                 keyCode;
  logic                       keyValid;
  logic                       irqEnable;
  logic                       irqAck;
  logic                       irq;
  logic [SEL_W-1:0]           sel;
  logic                       frozen;
  logic [DATA_W-1:0]          value;
  logic [DIGITS-1:0]          digSel;
  logic [3:0]                 digNibble;
  logic                       digBlank;

  modport master (
    output probeBus, keyCode, keyValid, irqEnable, irqAck,
    input  irq, sel, frozen, value, digSel, digNibble, digBlank
  );

  modport slave (
    input  probeBus, keyCode, keyValid, irqEnable, irqAck,
    output irq, sel, frozen, value, digSel, digNibble, digBlank
  );
endinterface

// File: rtl/debug_probe_mux_scanner.sv
// Digit scanner: a prescaler paces the digit index, the strobe is the one-hot of that index.
module digit_scanner #(
  parameter int SCAN_DIV = 16,
  parameter int DIGITS   = 4,
  parameter int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [IDX_W-1:0]  idx,
  output logic [DIGITS-1:0] dig_sel
);
  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [PRE_W-1:0] pre_r;
  logic [IDX_W-1:0] idx_r;

  // Prescaler and digit index; index advances on the terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r <= '0;
      idx_r <= '0;
    end else if (pre_r == PRE_W'(SCAN_DIV - 1)) begin
      pre_r <= '0;
      idx_r <= (idx_r == IDX_W'(DIGITS - 1)) ? IDX_W'(0) : idx_r + IDX_W'(1);
    end else begin
      pre_r <= pre_r + PRE_W'(1);
    end
  end

  assign idx     = idx_r;
  assign dig_sel = DIGITS'(1) << idx_r;
endmodule

// File: rtl/debug_probe_mux.sv
// Keyboard-driven probe selector with hold/snapshot, IRQ latch and 7-segment digit scanner.
// Optional leading-zero blanking is enabled by defining DEBUG_PROBE_BLANK_EN.
module debug_probe_mux
  import debug_probe_pkg::*;
#(
  parameter int CH_COUNT = 8,
  parameter int DATA_W   = 16,
  parameter int SCAN_DIV = 16
) (
  input logic              clk,
  input logic              rst,
  debug_probe_mux_if.slave bus
);
  localparam int SEL_W  = $clog2(CH_COUNT);
  localparam int DIGITS = DATA_W / 4;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DATA_W-1:0] probe_s [CH_COUNT];
  logic              key_q_r;
  logic              stroke_s;
  logic [3:0]        ch_idx_s;
  key_act_e          act_s;
  logic [SEL_W-1:0]  sel_r;
  logic [SEL_W-1:0]  sel_nxt_s;
  logic              frozen_r;
  logic [DATA_W-1:0] snap_r;
  logic [DATA_W-1:0] value_r;
  logic              pend_r;
  logic [IDX_W-1:0]  idx_s;
  logic [DIGITS-1:0] dig_sel_s;
  logic              blank_s;

  for (genvar k = 0; k < CH_COUNT; k++) begin : g_probe
    assign probe_s[k] = bus.probeBus[k*DATA_W +: DATA_W];
  end

  // Keystroke detection and key decode; channel keys beyond CH_COUNT are ignored.
  always_comb begin
    stroke_s = bus.keyValid & ~key_q_r;
    ch_idx_s = ch_key_index(bus.keyCode);
    act_s    = ACT_NONE;
    if (stroke_s) begin
      case (bus.keyCode)
        KEY_NEXT: act_s = ACT_NEXT;
        KEY_PREV: act_s = ACT_PREV;
        KEY_HOLD: act_s = ACT_HOLD;
        KEY_IRQ:  act_s = ACT_IRQ;
        default:  act_s = ((ch_idx_s != NO_CHAN) && ({28'd0, ch_idx_s} < CH_COUNT))
                          ? ACT_CHAN : ACT_NONE;
      endcase
    end else begin
      act_s = ACT_NONE;
    end
  end

  // Next channel selection with wrap in both directions.
  always_comb begin
    sel_nxt_s = sel_r;
    case (act_s)
      ACT_CHAN: sel_nxt_s = SEL_W'(ch_idx_s);
      ACT_NEXT: sel_nxt_s = (sel_r == SEL_W'(CH_COUNT - 1)) ? SEL_W'(0) : sel_r + SEL_W'(1);
      ACT_PREV: sel_nxt_s = (sel_r == SEL_W'(0)) ? SEL_W'(CH_COUNT - 1) : sel_r - SEL_W'(1);
      default:  sel_nxt_s = sel_r;
    endcase
  end

  // Selection, hold/snapshot, displayed value and IRQ latch; ack beats a same-cycle request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q_r  <= 1'b0;
      sel_r    <= '0;
      frozen_r <= 1'b0;
      snap_r   <= '0;
      value_r  <= '0;
      pend_r   <= 1'b0;
    end else begin
      key_q_r <= bus.keyValid;
      sel_r   <= sel_nxt_s;
      value_r <= frozen_r ? snap_r : probe_s[sel_r];
      if (act_s == ACT_HOLD) begin
        frozen_r <= ~frozen_r;
      end
      if ((act_s == ACT_HOLD) && !frozen_r) begin
        snap_r <= probe_s[sel_r];
      end else if (frozen_r && (sel_nxt_s != sel_r)) begin
        snap_r <= probe_s[sel_nxt_s];
      end
      if (bus.irqAck) begin
        pend_r <= 1'b0;
      end else if (act_s == ACT_IRQ) begin
        pend_r <= 1'b1;
      end
    end
  end

  digit_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DIGITS   (DIGITS),
    .IDX_W    (IDX_W)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .idx     (idx_s),
    .dig_sel (dig_sel_s)
  );

`ifdef DEBUG_PROBE_BLANK_EN
  assign blank_s = (idx_s != IDX_W'(0)) && ((value_r >> {idx_s, 2'b00}) == '0);
`else
  assign blank_s = 1'b0;
`endif

  assign bus.irq       = pend_r & bus.irqEnable;
  assign bus.sel       = sel_r;
  assign bus.frozen    = frozen_r;
  assign bus.value     = value_r;
  assign bus.digSel    = dig_sel_s;
  assign bus.digNibble = value_r[{idx_s, 2'b00} +: 4];
  assign bus.digBlank  = blank_s;
endmodule

// File: tb/tb_debug_probe_mux.sv
// Self-checking bench for debug_probe_mux: directed tables, corner sequences, random vs model.
module tb_debug_probe_mux;
  localparam int CH  = 8;
  localparam int DW  = 16;
  localparam int SD  = 4;
  localparam int DIG = DW / 4;
  localparam logic [8:0] K_N = 9'h031;
  localparam logic [8:0] K_M = 9'h03A;
  localparam logic [8:0] K_H = 9'h033;
  localparam logic [8:0] K_I = 9'h043;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  debug_probe_mux_if #(.CH_COUNT(CH), .DATA_W(DW)) bus ();
  debug_probe_mux_if #(.CH_COUNT(4), .DATA_W(DW)) bus4 ();

  debug_probe_mux #(.CH_COUNT(CH), .DATA_W(DW), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  debug_probe_mux #(.CH_COUNT(4), .DATA_W(DW), .SCAN_DIV(SD)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0]    ch_keys [8] = '{9'h04D, 9'h01C, 9'h032, 9'h021, 9'h02D, 9'h023, 9'h01B, 9'h02B};
  logic [DW-1:0] probe   [CH];

  // reference model state
  int            m_sel;
  bit            m_frozen;
  logic [DW-1:0] m_snap;
  logic [DW-1:0] m_value;
  bit            m_pend;
  bit            m_kv;
  int            m_cyc;

  typedef struct {
    logic [8:0] key;
    int         exp_sel;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int key_chan(input logic [8:0] c);
    for (int k = 0; k < 8; k++) begin
      if (ch_keys[k] == c) return k;
    end
    return -1;
  endfunction

  task automatic pack_probe();
    for (int k = 0; k < CH; k++) bus.probeBus[k*DW +: DW] = probe[k];
  endtask

  task automatic model_reset();
    m_sel = 0; m_frozen = 0; m_snap = '0; m_value = '0; m_pend = 0; m_kv = 0; m_cyc = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit stroke;
    int ch;
    int nsel;
    bit nfro;
    bit npend;
    logic [DW-1:0] nsnap;
    stroke = bus.keyValid && !m_kv;
    nsel = m_sel; nfro = m_frozen; nsnap = m_snap; npend = m_pend;
    if (stroke) begin
      ch = key_chan(bus.keyCode);
      if (ch >= 0) begin
        if (ch < CH) nsel = ch;
      end else if (bus.keyCode == K_N) nsel = (m_sel + 1) % CH;
      else if (bus.keyCode == K_M) nsel = (m_sel + CH - 1) % CH;
      else if (bus.keyCode == K_H) begin
        nfro = !m_frozen;
        if (!m_frozen) nsnap = probe[m_sel];
      end else if (bus.keyCode == K_I) npend = 1;
    end
    if (m_frozen && nsel != m_sel) nsnap = probe[nsel];
    if (bus.irqAck) npend = 0;
    m_value  = m_frozen ? m_snap : probe[m_sel];
    m_sel    = nsel;
    m_frozen = nfro;
    m_snap   = nsnap;
    m_pend   = npend;
    m_kv     = bus.keyValid;
    m_cyc++;
  endtask

  task automatic check_all();
    int idx;
    logic [DW-1:0] sh;
    bit exp_blank;
    idx = (m_cyc / SD) % DIG;
    sh  = m_value >> (4 * idx);
`ifdef DEBUG_PROBE_BLANK_EN
    exp_blank = (idx > 0) && (sh == '0);
`else
    exp_blank = 1'b0;
`endif
    chk("sel", 32'(bus.sel), 32'(m_sel));
    chk("frozen", 32'(bus.frozen), 32'(m_frozen));
    chk("value", 32'(bus.value), 32'(m_value));
    chk("irq", 32'(bus.irq), 32'(m_pend & bus.irqEnable));
    chk("digSel", 32'(bus.digSel), 32'(1 << idx));
    chk("digNibble", 32'(bus.digNibble), 32'(sh[3:0]));
    chk("digBlank", 32'(bus.digBlank), 32'(exp_blank));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic key_down(input logic [8:0] c);
    bus.keyCode = c; bus.keyValid = 1'b1; step();
  endtask

  task automatic key_up();
    bus.keyValid = 1'b0; step();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    #2 rst = 1'b1;
  endtask

  task automatic key4(input logic [8:0] c, input int exp_sel, input string name);
    bus4.keyCode = c; bus4.keyValid = 1'b1; step();
    chk(name, 32'(bus4.sel), 32'(exp_sel));
    bus4.keyValid = 1'b0; step();
  endtask

  logic [3:0] scan_sel [4] = '{4'd1, 4'd2, 4'd4, 4'd8};
  logic [3:0] scan_nib [4] = '{4'h5, 4'hA, 4'h0, 4'h0};
  bit         scan_blk [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [8:0] pool [14] = '{9'h04D, 9'h01C, 9'h032, 9'h021, 9'h02D, 9'h023, 9'h01B, 9'h02B,
                            9'h031, 9'h03A, 9'h033, 9'h043, 9'h1FF, 9'h000};

  initial begin
    tbl[0] = '{9'h01C, 1}; tbl[1] = '{K_N, 2};    tbl[2] = '{9'h02B, 7};
    tbl[3] = '{K_N, 0};    tbl[4] = '{K_M, 7};    tbl[5] = '{9'h04D, 0};
    tbl[6] = '{K_M, 7};    tbl[7] = '{9'h01B, 6}; tbl[8] = '{9'h1FF, 6};
    tbl[9] = '{9'h032, 2};

    for (int k = 0; k < CH; k++) probe[k] = 16'(16'h1111 * k);
    pack_probe();
    bus.keyCode = '0; bus.keyValid = 1'b0; bus.irqEnable = 1'b0; bus.irqAck = 1'b0;
    bus4.keyCode = '0; bus4.keyValid = 1'b0; bus4.irqEnable = 1'b0; bus4.irqAck = 1'b0;
    for (int k = 0; k < 4; k++) bus4.probeBus[k*DW +: DW] = 16'(16'h1111 * k);

    #6;
    do_reset();
    chk("reset_digSel", 32'(bus.digSel), 32'd1);
    chk("reset_value", 32'(bus.value), 32'd0);

    // channel key table
    for (int i = 0; i < 10; i++) begin
      key_down(tbl[i].key);
      chk("tbl_sel", 32'(bus.sel), 32'(tbl[i].exp_sel));
      key_up();
      chk("tbl_value", 32'(bus.value), 32'h1111 * 32'(tbl[i].exp_sel));
    end

    // hold, probe change, step while frozen, release
    key_down(K_H); key_up();
    probe[2] = 16'hBEEF; pack_probe();
    step(); step();
    chk("hold_value", 32'(bus.value), 32'h2222);
    key_down(K_N);
    chk("hold_next_sel", 32'(bus.sel), 32'd3);
    key_up();
    chk("hold_snap", 32'(bus.value), 32'h3333);
    key_down(K_H); key_up(); step();
    chk("unhold_frozen", 32'(bus.frozen), 32'd0);
    chk("unhold_value", 32'(bus.value), 32'h3333);
    probe[2] = 16'h2222; pack_probe();

    // IRQ latch and ack priority
    key_down(K_I); key_up();
    chk("irq_disabled", 32'(bus.irq), 32'd0);
    bus.irqEnable = 1'b1; step();
    chk("irq_enabled", 32'(bus.irq), 32'd1);
    bus.irqAck = 1'b1; step(); bus.irqAck = 1'b0; step();
    chk("irq_acked", 32'(bus.irq), 32'd0);
    bus.irqAck = 1'b1; key_down(K_I); bus.irqAck = 1'b0; key_up();
    chk("irq_ack_wins", 32'(bus.irq), 32'd0);

    // smaller channel count: out-of-range channel keys ignored
    key4(9'h021, 3, "ch4_sel_c");
    key4(9'h02D, 3, "ch4_ignore_r");
    key4(9'h02B, 3, "ch4_ignore_f");
    key4(K_N, 0, "ch4_wrap_next");
    key4(K_M, 3, "ch4_wrap_prev");
    chk("ch4_value", 32'(bus4.value), 32'h3333);

    // scanner timing on 00A5
    probe[0] = 16'h00A5; pack_probe();
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      step();
      chk("scan_sel", 32'(bus.digSel), 32'(scan_sel[(n / SD) % 4]));
      chk("scan_nib", 32'(bus.digNibble), 32'(scan_nib[(n / SD) % 4]));
`ifdef DEBUG_PROBE_BLANK_EN
      chk("scan_blank", 32'(bus.digBlank), 32'(scan_blk[(n / SD) % 4]));
`else
      chk("scan_blank", 32'(bus.digBlank), 32'd0);
`endif
    end

    // keyValid held for 10 clocks is one keystroke
    bus.keyCode = K_N; bus.keyValid = 1'b1;
    for (int n = 0; n < 10; n++) step();
    bus.keyValid = 1'b0; step();
    chk("long_press", 32'(bus.sel), 32'd1);

    // asynchronous reset mid-scan
    key_down(9'h021); key_up();
    key_down(K_I); key_up();
    key_down(K_H); key_up();
    step(); step();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(bus.sel), 32'd0);
    chk("mid_rst_frozen", 32'(bus.frozen), 32'd0);
    chk("mid_rst_value", 32'(bus.value), 32'd0);
    chk("mid_rst_irq", 32'(bus.irq), 32'd0);
    chk("mid_rst_digSel", 32'(bus.digSel), 32'd1);
    chk("mid_rst_nibble", 32'(bus.digNibble), 32'd0);
    chk("mid_rst_blank", 32'(bus.digBlank), 32'd0);
    model_reset();
    #2 rst = 1'b1;

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3) == 0) bus.keyValid = ~bus.keyValid;
      if (!bus.keyValid) bus.keyCode = pool[$urandom_range(13)];
      bus.irqAck = ($urandom_range(9) == 0);
      if ($urandom_range(15) == 0) bus.irqEnable = ~bus.irqEnable;
      if ($urandom_range(3) == 0) begin
        probe[$urandom_range(CH - 1)] = 16'($urandom);
        pack_probe();
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
